intra4_recon_ctx: RTL
=====================

Name: intra4_recon_ctx

Overview:
- Consumer end of the 4x4 intra predictor interface. It takes the predictor's 16-pixel `dst` block and a dequantised residual block, and reconstructs `clip(pred+res)`.
- It streams reconstructed 4x4 blocks out with a valid/ready handshake.
- It maintains the neighbour context (top, left, top_left) fed back to the 4x4 predictors for the next sub-block of a 16x16 macroblock, visited in raster order blk 0..15.

Parameters:
- BIT_WIDTH, 8, pixel width.
- BLOCK_SIZE, 4, sub-block edge; the macroblock is 4*BLOCK_SIZE square.
- RES_WIDTH, 16, signed residual sample width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- mb_start  in  1  pulse; loads MB neighbours; honoured only in IDLE.
- mb_top  in  BIT_WIDTH*16  row above MB, byte i = column i.
- mb_left  in  BIT_WIDTH*16  column left of MB, byte i = row i.
- mb_top_left  in  BIT_WIDTH  corner pixel above-left of MB.
- in_valid  in  1  pred/res valid.
- in_ready  out  1  block accepted when in_valid && in_ready.
- pred  in  BIT_WIDTH*16  prediction, byte k = row k/4, col k%4.
- res  in  RES_WIDTH*16  signed residual, same ordering.
- out_valid  out  1  recon valid.
- out_ready  in  1  downstream ready.
- recon  out  BIT_WIDTH*16  reconstructed block.
- out_blk  out  4  index of recon block.
- out_last  out  1  high with out_valid when out_blk==15.
- nb_top  out  BIT_WIDTH*4  top neighbours for the next expected block.
- nb_left  out  BIT_WIDTH*4  left neighbours for the next expected block.
- nb_top_left  out  BIT_WIDTH  corner for the next expected block.
- blk_idx  out  4  next expected block index (by=blk_idx[3:2], bx=blk_idx[1:0]).

Behaviour:
- Reset (async): state IDLE.
  - in_ready=0, out_valid=0, out_last=0, out_blk=0, blk_idx=0, recon=0.
  - All buffers and nb_* = 0.
  - Reset mid-MB discards everything; no partial output.
- States: IDLE, RUN, DRAIN.
  - IDLE + mb_start -> RUN: blk_idx=0; store mb_top into top buffer (4 slots of 4 px); store mb_left in an MB-left register; corner=mb_top_left.
  - mb_start outside IDLE is ignored.
  - RUN: accept on the 16th handshake (blk_idx==15) -> DRAIN.
  - DRAIN: out handshake with out_last -> IDLE.
- in_ready = (state==RUN) && (!out_valid || out_ready). There is no combinational path in_valid->in_ready.
- Recon per pixel: `s = {0,pred} + sign-extended res`, computed at RES_WIDTH+2 bits signed.
  - s<0 -> 0; s>2^BIT_WIDTH-1 -> 2^BIT_WIDTH-1; else s.
  - Registered: recon/out_blk valid the cycle after accept (latency 1). Throughput is 1 block/cycle.
- out_valid set on accept; held with stable data while !out_ready; cleared on handshake unless a new accept occurs the same cycle (new data replaces it).
- Context update on accept of block (by,bx), registered the same edge:
  - next corner = old top slot bx pixel 3, captured before overwrite, when bx<3. If bx==3, next corner = mb_left row 4(by+1)-1, or don't care after blk 15.
  - top slot bx <= recon row 3.
  - left buffer <= recon column 3.
  - blk_idx <= blk_idx+1, wrapping to 0 after 15.
- nb_* outputs are combinational from registers and reflect blk_idx:
  - nb_top = top slot bx.
  - nb_left = mb_left rows 4by..4by+3 if bx==0, else the left buffer.
  - nb_top_left = corner. For bx==0, by>0 it is mb_left[4by-1]; for blk 0 it is mb_top_left.
  - Valid from the cycle after mb_start or after the previous accept, so a back-to-back accept uses updated context.
- Simultaneous out handshake and new accept in RUN: allowed, no bubble.

Decomposition:
- Shared package: BIT_WIDTH/BLOCK_SIZE defaults, MB_BLOCKS=16, state encoding, pixel byte-index helper constants shared with the predictor set.
- One sub-module: `recon_clip_px`, a single-pixel add-and-clip unit, instantiated 16x.

Test Plan:
- Reset, then mb_start with mb_top=all 0x10, mb_left=all 0x20, mb_top_left=0x30 -> nb_top=0x10101010, nb_left=0x20202020, nb_top_left=0x30, blk_idx=0.
- Block 0: pred all 0x80, res all +5 -> recon all 0x85, out_blk=0. Next cycle: nb_top=0x10101010 (slot1), nb_left=0x85858585, nb_top_left=0x10.
- Clipping: pred 0xF0, res +0x40 -> 0xFF; pred 0x05, res -20 -> 0x00; res -32768 -> 0x00 with no wrap.
- Backpressure: out_ready=0 for 3 cycles after block 2 -> out_valid held, recon stable, in_ready=0; release -> handshake, and block 3 is accepted the same cycle.
- Full MB: 16 back-to-back blocks with out_ready=1 -> 16 outputs on consecutive cycles, out_last only on blk 15, state returns to IDLE. A mb_start asserted during blk 7 is ignored.
- Row wrap: after blk 3, nb_left=mb_left bytes 4..7, nb_top=recon row 3 of blk 0, nb_top_left=mb_left byte 3. Async rst at blk 9 -> all outputs 0 immediately, and no output follows.

Source files
------------

// File: rtl/intra4_recon_ctx_pkg.sv
// Shared definitions for the 4x4 intra reconstruction / neighbour-context slice.
package intra4_recon_ctx_pkg;

    localparam int unsigned BIT_WIDTH_DEF  = 8;
    localparam int unsigned BLOCK_SIZE_DEF = 4;
    localparam int unsigned RES_WIDTH_DEF  = 16;
    localparam int unsigned MB_BLOCKS      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Byte index of a pixel inside a packed 4x4 block (row-major).
    function automatic int unsigned px_byte(input int unsigned row, input int unsigned col);
        return row * BLOCK_SIZE_DEF + col;
    endfunction

endpackage

// File: rtl/intra4_recon_ctx_recon_clip_px.sv
// Single-pixel reconstruction: prediction plus signed residual, clipped to pixel range.
module recon_clip_px
    import intra4_recon_ctx_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int unsigned RES_WIDTH = RES_WIDTH_DEF
) (
    input  logic [BIT_WIDTH-1:0] pred,
    input  logic [RES_WIDTH-1:0] res,
    output logic [BIT_WIDTH-1:0] px
);

    localparam int unsigned SW = RES_WIDTH + 2;

    logic [SW-1:0] sum;

    // Two guard bits keep the sum exact, so the MSB is a true sign bit.
    always_comb begin
        sum = {{(SW-BIT_WIDTH){1'b0}}, pred} + {{2{res[RES_WIDTH-1]}}, res};
        if (sum[SW-1])
            px = '0;
        else if (|sum[SW-2:BIT_WIDTH])
            px = '1;
        else
            px = sum[BIT_WIDTH-1:0];
    end

endmodule

// File: rtl/intra4_recon_ctx.sv
// Reconstructs 4x4 intra blocks and keeps the top/left/corner context for the
// next sub-block of a 16x16 macroblock visited in raster order.
module intra4_recon_ctx
    import intra4_recon_ctx_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = BIT_WIDTH_DEF,
    parameter int unsigned BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int unsigned RES_WIDTH  = RES_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mb_start,
    input  logic [BIT_WIDTH*16-1:0] mb_top,
    input  logic [BIT_WIDTH*16-1:0] mb_left,
    input  logic [BIT_WIDTH-1:0]    mb_top_left,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIT_WIDTH*16-1:0] pred,
    input  logic [RES_WIDTH*16-1:0] res,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIT_WIDTH*16-1:0] recon,
    output logic [3:0]              out_blk,
    output logic                    out_last,
    output logic [BIT_WIDTH*4-1:0]  nb_top,
    output logic [BIT_WIDTH*4-1:0]  nb_left,
    output logic [BIT_WIDTH-1:0]    nb_top_left,
    output logic [3:0]              blk_idx
);

    localparam int unsigned NPX   = BLOCK_SIZE * BLOCK_SIZE;
    localparam int unsigned ROW_W = BIT_WIDTH * BLOCK_SIZE;
    localparam logic [3:0]  LAST_BLK = 4'(MB_BLOCKS - 1);

    state_t                  state;
    logic [ROW_W-1:0]        top_buf      [4];
    logic [ROW_W-1:0]        mb_left_rows [4];
    logic [ROW_W-1:0]        left_buf;
    logic [BIT_WIDTH-1:0]    corner;
    logic [BIT_WIDTH*16-1:0] recon_c;
    logic [ROW_W-1:0]        row3;
    logic [ROW_W-1:0]        col3;
    logic [1:0]              by;
    logic [1:0]              bx;
    logic                    accept;

    assign by = blk_idx[3:2];
    assign bx = blk_idx[1:0];

    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < NPX; k++) begin : g_px
        recon_clip_px #(
            .BIT_WIDTH(BIT_WIDTH),
            .RES_WIDTH(RES_WIDTH)
        ) u_px (
            .pred(pred[k*BIT_WIDTH +: BIT_WIDTH]),
            .res (res[k*RES_WIDTH +: RES_WIDTH]),
            .px  (recon_c[k*BIT_WIDTH +: BIT_WIDTH])
        );
    end

    assign row3 = recon_c[px_byte(BLOCK_SIZE-1, 0)*BIT_WIDTH +: ROW_W];
    for (genvar r = 0; r < BLOCK_SIZE; r++) begin : g_col3
        assign col3[r*BIT_WIDTH +: BIT_WIDTH] = recon_c[px_byte(r, BLOCK_SIZE-1)*BIT_WIDTH +: BIT_WIDTH];
    end

    assign nb_top      = top_buf[bx];
    assign nb_left     = (bx == 2'd0) ? mb_left_rows[by] : left_buf;
    assign nb_top_left = corner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            blk_idx   <= '0;
            left_buf  <= '0;
            corner    <= '0;
            recon     <= '0;
            out_valid <= 1'b0;
            out_blk   <= '0;
            out_last  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                top_buf[i]      <= '0;
                mb_left_rows[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mb_start) begin
                        state   <= ST_RUN;
                        blk_idx <= '0;
                        corner  <= mb_top_left;
                        for (int unsigned i = 0; i < 4; i++) begin
                            top_buf[i]      <= mb_top[i*ROW_W +: ROW_W];
                            mb_left_rows[i] <= mb_left[i*ROW_W +: ROW_W];
                        end
                    end
                end
                ST_RUN: begin
                    if (accept && blk_idx == LAST_BLK)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (out_valid && out_ready && out_last)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (accept) begin
                // Corner for the next block is read from the slot before it is overwritten.
                if (bx == 2'd3)
                    corner <= mb_left_rows[by][ROW_W-1 -: BIT_WIDTH];
                else
                    corner <= top_buf[bx][ROW_W-1 -: BIT_WIDTH];
                top_buf[bx] <= row3;
                left_buf    <= col3;
                blk_idx     <= blk_idx + 4'd1;
                recon       <= recon_c;
                out_blk     <= blk_idx;
                out_last    <= (blk_idx == LAST_BLK);
                out_valid   <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
